// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter between the IF and MEM pipeline stages.
// Round-robin grant, multi-cycle request/ready handshake with timeout, one-cycle ack.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    output logic                  if_stall,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_ack,
    output logic                  mem_stall,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_dout,
    input  logic [DATA_WIDTH-1:0] ram_din,
    input  logic                  ram_ready,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;
    typedef enum logic {OwnIf, OwnMem} owner_e;

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    state_e          state_q;
    owner_e          owner_q;
    owner_e          prio_q;
    logic [CntW-1:0] cnt_q;
    logic            mem_req;
    logic            grant_if;
    logic            grant_mem;

    assign mem_req = mem_ren | mem_wen;

    // In ACK the owner is still presenting the request it was just acked for, so only
    // the other stage may be granted back-to-back.
    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        case (state_q)
            StIdle: begin
                if (if_req && mem_req) begin
                    grant_mem = (prio_q == OwnMem);
                    grant_if  = (prio_q == OwnIf);
                end else begin
                    grant_mem = mem_req;
                    grant_if  = if_req;
                end
            end
            StAck: begin
                grant_if  = (owner_q == OwnMem) && if_req;
                grant_mem = (owner_q == OwnIf) && mem_req;
            end
            default: begin
                grant_if  = 1'b0;
                grant_mem = 1'b0;
            end
        endcase
    end

    // Ack is withheld when the stage withdrew its request (pipeline flush).
    assign if_ack    = (state_q == StAck) && (owner_q == OwnIf) && if_req;
    assign mem_ack   = (state_q == StAck) && (owner_q == OwnMem) && mem_req;
    assign if_stall  = if_req & ~if_ack;
    assign mem_stall = mem_req & ~mem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= OwnIf;
            prio_q      <= OwnMem;
            cnt_q       <= '0;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_dout    <= '0;
            if_rdata    <= '0;
            mem_rdata   <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StAck: begin
                    if (state_q == StAck) begin
                        prio_q <= (owner_q == OwnIf) ? OwnMem : OwnIf;
                    end
                    if (grant_if || grant_mem) begin
                        state_q  <= StBusy;
                        cnt_q    <= '0;
                        ram_cs   <= 1'b1;
                        owner_q  <= grant_mem ? OwnMem : OwnIf;
                        ram_addr <= grant_mem ? mem_addr : if_addr;
                        ram_we   <= grant_mem & mem_wen;
                        if (grant_mem) begin
                            ram_dout <= mem_wdata;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StBusy: begin
                    if (ram_ready || (cnt_q == CntMax)) begin
                        state_q <= StAck;
                        ram_cs  <= 1'b0;
                        ram_we  <= 1'b0;
                        // A timed-out read returns zero rather than stale bus data.
                        if (!ram_we) begin
                            if (owner_q == OwnIf) begin
                                if_rdata <= ram_ready ? ram_din : '0;
                            end else begin
                                mem_rdata <= ram_ready ? ram_din : '0;
                            end
                        end
                        if (!ram_ready) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ram_cs  <= 1'b0;
                    ram_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          if_stall;
    logic          mem_ren = 1'b0;
    logic          mem_wen = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          mem_stall;
    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] ram_din = '0;
    logic          ram_ready = 1'b0;
    logic          timeout_err;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ack     (if_ack),
        .if_stall   (if_stall),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .mem_stall  (mem_stall),
        .ram_cs     (ram_cs),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_dout   (ram_dout),
        .ram_din    (ram_din),
        .ram_ready  (ram_ready),
        .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one record for the transaction in flight plus the
    // visible register values. Advanced once per cycle from the inputs that
    // the coming rising edge will sample.
    bit          m_live;      // RAM access outstanding
    bit          m_done;      // access finished, this is its ack cycle
    bit          m_own_mem;   // transaction belongs to MEM
    bit          m_write;
    bit          m_pref_mem;  // who wins a tie
    int          m_age;       // busy cycles spent so far
    logic [31:0] m_addr, m_dout, m_if_rd, m_mem_rd;
    bit          m_terr;
    bit          saw_if_ack = 1'b0;
    bit          saw_mem_ack = 1'b0;

    task model_reset();
        m_live = 0; m_done = 0; m_own_mem = 0; m_write = 0; m_pref_mem = 1; m_age = 0;
        m_addr = '0; m_dout = '0; m_if_rd = '0; m_mem_rd = '0; m_terr = 0;
        saw_if_ack = 0; saw_mem_ack = 0;
    endtask

    task start(input bit to_mem);
        m_live    = 1;
        m_own_mem = to_mem;
        m_age     = 0;
        m_write   = to_mem && mem_wen;
        m_addr    = to_mem ? mem_addr : if_addr;
        if (to_mem) m_dout = mem_wdata;
    endtask

    task finish(input logic [31:0] d);
        m_live = 0;
        m_done = 1;
        if (!m_write) begin
            if (m_own_mem) m_mem_rd = d;
            else m_if_rd = d;
        end
    endtask

    task model_step();
        bit want_if, want_mem;
        want_if  = if_req;
        want_mem = mem_ren || mem_wen;
        if (m_done) begin
            m_done     = 0;
            m_pref_mem = !m_own_mem;
            if (m_own_mem ? want_if : want_mem) start(!m_own_mem);
        end else if (m_live) begin
            m_age++;
            if (ram_ready) finish(ram_din);
            else if (m_age == TO) begin
                finish('0);
                m_terr = 1;
            end
        end else if (want_if || want_mem) begin
            start(want_mem && (!want_if || m_pref_mem));
        end
    endtask

    initial begin
        bit e_if_ack, e_mem_ack;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
            end else begin
                e_if_ack  = m_done && !m_own_mem && if_req;
                e_mem_ack = m_done && m_own_mem && (mem_ren || mem_wen);
                chk("ram_cs", ram_cs, m_live);
                chk("ram_we", ram_we, m_live && m_write);
                chk("ram_addr", ram_addr, m_addr);
                if (m_live && m_write) chk("ram_dout", ram_dout, m_dout);
                chk("if_ack", if_ack, e_if_ack);
                chk("mem_ack", mem_ack, e_mem_ack);
                chk("if_stall", if_stall, if_req && !e_if_ack);
                chk("mem_stall", mem_stall, (mem_ren || mem_wen) && !e_mem_ack);
                chk("if_rdata", if_rdata, m_if_rd);
                chk("mem_rdata", mem_rdata, m_mem_rd);
                chk("timeout_err", timeout_err, m_terr);
                saw_if_ack  = e_if_ack;
                saw_mem_ack = e_mem_ack;
                model_step();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1; if_req = 0; mem_ren = 0; mem_wen = 0; ram_ready = 0;
        @(posedge clk);
        #2;
        rst = 0;
    endtask

    task automatic new_mem_req(input bit on);
        logic [1:0] k;
        k         = 2'($urandom_range(1, 3));
        mem_ren   = on && k[0];
        mem_wen   = on && k[1];
        mem_addr  = $urandom & 32'h0000_0FFC;
        mem_wdata = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        bit          done;
        int          ng;
        bit          prev_cs;
        int          last_if, last_mem;
        logic [31:0] g[8];
        int unsigned ready_pct;

        // Reset values
        do_reset();
        at_neg();
        chk("rst_cs", ram_cs, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_terr", timeout_err, 0);

        // Single fetch, minimum latency
        tick(); if_req = 1; if_addr = 32'h10;
        at_neg(); chk("t1_stall_c0", if_stall, 1); chk("t1_cs_c0", ram_cs, 0);
        tick(); ram_ready = 1; ram_din = 32'h8C01_0004;
        at_neg(); chk("t1_cs_c1", ram_cs, 1); chk("t1_addr_c1", ram_addr, 32'h10);
        chk("t1_we_c1", ram_we, 0); chk("t1_stall_c1", if_stall, 1);
        tick(); ram_ready = 0;
        at_neg(); chk("t1_ack_c2", if_ack, 1); chk("t1_rdata_c2", if_rdata, 32'h8C01_0004);
        chk("t1_stall_c2", if_stall, 0);
        tick(); if_req = 0;

        // Simultaneous requests: MEM first, then IF with no idle bubble
        do_reset();
        if_req = 1; if_addr = 32'h20; mem_wen = 1; mem_addr = 32'h40; mem_wdata = 32'hDEAD;
        ram_ready = 1; ram_din = 32'h5555;
        at_neg();
        tick();
        at_neg(); chk("t2_cs", ram_cs, 1); chk("t2_we", ram_we, 1);
        chk("t2_dout", ram_dout, 32'hDEAD); chk("t2_addr", ram_addr, 32'h40);
        tick();
        at_neg(); chk("t2_mem_ack", mem_ack, 1); chk("t2_cs_ack", ram_cs, 0);
        tick(); mem_wen = 0;
        at_neg(); chk("t2_if_cs", ram_cs, 1); chk("t2_if_addr", ram_addr, 32'h20);
        chk("t2_if_we", ram_we, 0); chk("t2_mem_rdata", mem_rdata, 0);
        tick();
        at_neg(); chk("t2_if_ack", if_ack, 1); chk("t2_if_rdata", if_rdata, 32'h5555);
        tick(); if_req = 0; ram_ready = 0;

        // Continuous contention: strict alternation
        do_reset();
        if_req = 1; if_addr = 32'h100; mem_ren = 1; mem_addr = 32'h200;
        ram_ready = 1; ram_din = 32'hA5A5_0000;
        ng = 0; prev_cs = 0; last_if = -1; last_mem = -1;
        for (int c = 0; c < 12; c++) begin
            bit a_if, a_mem;
            at_neg();
            if (ram_cs && !prev_cs && ng < 8) begin
                g[ng] = ram_addr;
                ng++;
            end
            prev_cs = ram_cs;
            a_if = if_ack;
            a_mem = mem_ack;
            if (a_if) begin
                if (last_if >= 0) chk("t3_if_gap", (c - last_if) <= 4, 1);
                last_if = c;
            end
            if (a_mem) begin
                if (last_mem >= 0) chk("t3_mem_gap", (c - last_mem) <= 4, 1);
                last_mem = c;
            end
            tick();
            if (a_if) if_addr = if_addr + 4;
            if (a_mem) mem_addr = mem_addr + 4;
        end
        if_req = 0; mem_ren = 0;
        chk("t3_grants", ng, 6);
        for (int i = 0; i < 6; i++) chk("t3_grant_order", g[i][11:8], (i % 2 == 0) ? 2 : 1);
        repeat (4) tick();
        ram_ready = 0;

        // Load with three wait cycles
        tick(); mem_ren = 1; mem_addr = 32'h44; ram_din = 32'h1234; ram_ready = 0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            at_neg();
            cnt += int'(ram_cs);
            if (c < 5) begin
                chk("t4_stall", mem_stall, 1);
                chk("t4_noack", mem_ack, 0);
            end else begin
                chk("t4_ack", mem_ack, 1);
                chk("t4_rdata", mem_rdata, 32'h1234);
                chk("t4_stall_end", mem_stall, 0);
            end
            tick();
            ram_ready = (c == 3);
        end
        mem_ren = 0;
        chk("t4_cs_cycles", cnt, 4);

        // Fetch that never sees ram_ready
        tick(); if_req = 1; if_addr = 32'h300; ram_ready = 0; ram_din = 32'hFFFF_FFFF;
        cnt = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            at_neg();
            if (c == 0) chk("t5_err_before", timeout_err, 0);
            cnt += int'(ram_cs);
            if (if_ack) begin
                done = 1;
                chk("t5_rdata", if_rdata, 0);
                chk("t5_err", timeout_err, 1);
                chk("t5_busy_cycles", cnt, 16);
                chk("t5_ack_cycle", c, 17);
            end
            tick();
        end
        if_req = 0;
        if (!done) chk("t5_timeout_ack_seen", 0, 1);

        // Flushed fetch completes on the RAM without an ack
        tick(); if_req = 1; if_addr = 32'h400; ram_din = 32'h0BAD_F00D;
        at_neg();
        tick();
        at_neg(); chk("t6b_cs_c1", ram_cs, 1);
        tick(); if_req = 0;
        at_neg(); chk("t6b_cs_c2", ram_cs, 1); chk("t6b_stall", if_stall, 0);
        tick(); ram_ready = 1;
        at_neg(); chk("t6b_cs_c3", ram_cs, 1);
        tick(); ram_ready = 0;
        at_neg(); chk("t6b_noack", if_ack, 0); chk("t6b_cs_c4", ram_cs, 0);
        chk("t6b_err_sticky", timeout_err, 1);
        tick();

        // Reset in the middle of a load
        mem_ren = 1; mem_addr = 32'h48;
        at_neg();
        tick();
        at_neg(); chk("t6_cs_busy", ram_cs, 1);
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk("t6_cs_async", ram_cs, 0);
        chk("t6_noack", mem_ack, 0);
        chk("t6_err_cleared", timeout_err, 0);
        mem_ren = 0;
        @(posedge clk);
        #2;
        rst = 0;
        if_req = 1; if_addr = 32'h500; ram_ready = 1; ram_din = 32'h600D;
        at_neg(); chk("t6_idle", ram_cs, 0);
        tick();
        at_neg(); chk("t6_cs_new", ram_cs, 1); chk("t6_addr_new", ram_addr, 32'h500);
        tick();
        at_neg(); chk("t6_ack_new", if_ack, 1); chk("t6_rdata_new", if_rdata, 32'h600D);
        tick(); if_req = 0; ram_ready = 0;

        // Randomized traffic against the model
        ready_pct = 60;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (c % 50 == 0) ready_pct = ($urandom_range(0, 3) == 0) ? 2 : 60;
            ram_ready = ($urandom_range(0, 99) < ready_pct);
            ram_din   = $urandom;
            if (if_req) begin
                if (saw_if_ack) begin
                    if_req  = ($urandom_range(0, 1) == 1);
                    if_addr = $urandom & 32'h0000_0FFC;
                end else if ($urandom_range(0, 59) == 0) begin
                    if_req = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req  = 1;
                if_addr = $urandom & 32'h0000_0FFC;
            end
            if (mem_ren || mem_wen) begin
                if (saw_mem_ack) new_mem_req($urandom_range(0, 1) == 1);
                else if ($urandom_range(0, 59) == 0) begin
                    mem_ren = 0;
                    mem_wen = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                new_mem_req(1);
            end
        end
        if_req = 0; mem_ren = 0; mem_wen = 0; ram_ready = 1;
        repeat (25) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
